// File: rtl/distributor.sv
// distributor_fifo: per-channel queue used by the distributor.
// Ports: push/push_data write a word, pop_ready consumes the head when valid,
//   valid/head_data present the head from registered state, full flags DEPTH words held.
// Latency: one cycle from push to valid. A pop is taken only when valid && pop_ready.
module distributor_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;

  assign valid     = (count != '0);
  assign pop       = valid && pop_ready;
  assign full      = (count == DEPTH_C);
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  // A push into a full queue is only issued together with a pop; the head is
  // read from mem before the edge, so overwriting that slot is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// distributor: 1-to-N splitter; each word is routed by its embedded destination field.
// Ports: RECEIVE_* input stream, SEND_* per-channel output streams (channel i data on
//   SEND_DATA[DATA_WIDTH*i +: DATA_WIDTH]), DROPPED/DROP_COUNT report out-of-range words.
// Latency one cycle, one word per cycle; input stalls only when the head word's channel
// is full and not being drained this cycle. Out-of-range words are always accepted.
module distributor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int DEST_LSB    = 0,
  parameter int DEST_WIDTH  = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]             RECEIVE_DATA,
  output logic                              RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]            SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA,
  input  logic [CONNECT_NUM-1:0]            SEND_READY,
  output logic                              DROPPED,
  output logic [15:0]                       DROP_COUNT
);
  // Destination is widened by one bit so it can be compared against CONNECT_NUM
  // even when CONNECT_NUM == 2**DEST_WIDTH.
  localparam int DEST_W1 = DEST_WIDTH + 1;
  localparam logic [DEST_W1-1:0] CONNECT_C = DEST_W1'(CONNECT_NUM);

  logic [DEST_W1-1:0]     dest;
  logic                   in_range;
  logic                   sel_ok;
  logic                   drop;
  logic [CONNECT_NUM-1:0] push;
  logic [CONNECT_NUM-1:0] full;

  assign dest     = {1'b0, RECEIVE_DATA[DEST_LSB +: DEST_WIDTH]};
  assign in_range = (dest < CONNECT_C);

  // Selected channel can take a word if it has room, or if it is full but its
  // head leaves this same cycle (full implies valid, so ready means a pop).
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (dest == DEST_W1'(i)) sel_ok = !full[i] || SEND_READY[i];
    end
  end

  assign RECEIVE_READY = in_range ? sel_ok : 1'b1;
  assign drop          = RECEIVE_VALID && !in_range;

  for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_chan
    assign push[g] = RECEIVE_VALID && RECEIVE_READY && (dest == DEST_W1'(g));

    distributor_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push[g]),
      .push_data (RECEIVE_DATA),
      .pop_ready (SEND_READY[g]),
      .valid     (SEND_VALID[g]),
      .head_data (SEND_DATA[DATA_WIDTH*g +: DATA_WIDTH]),
      .full      (full[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DROPPED    <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      DROPPED <= drop;
      if (drop && (DROP_COUNT != 16'hFFFF)) DROP_COUNT <= DROP_COUNT + 16'd1;
    end
  end
endmodule
